// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port synchronous memory between
// two requesters. Requests use valid/ready handshakes. Read data comes back through
// a registered response stage with backpressure. Writes complete on the handshake
// and produce no response.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_cmd,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_din,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_dout,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_cmd,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_din,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_dout,
  output logic                  mem_cmd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  logic inflight0, inflight1;
  logic rr;
  logic elig0, elig1;
  logic grant0, grant1;

  // Eligibility and single grant. A read is held off while the requester's previous
  // read is still in the memory, or while its response slot is full and not being
  // drained this cycle. Reset masks every grant so that no memory write can slip
  // through while rst is asserted.
  always_comb begin
    elig0  = !rst && req0_valid &&
             (req0_cmd || (!inflight0 && (!rsp0_valid || rsp0_ready)));
    elig1  = !rst && req1_valid &&
             (req1_cmd || (!inflight1 && (!rsp1_valid || rsp1_ready)));
    grant0 = elig0 && (!elig1 || !rr);
    grant1 = elig1 && (!elig0 || rr);
    req0_ready = grant0;
    req1_ready = grant1;
  end

  // Memory drive follows the winner. When nothing is granted, an idle read of
  // address 0 is issued.
  always_comb begin
    mem_cmd  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant0) begin
      mem_cmd  = req0_cmd;
      mem_addr = req0_addr;
      mem_din  = req0_din;
    end else if (grant1) begin
      mem_cmd  = req1_cmd;
      mem_addr = req1_addr;
      mem_din  = req1_din;
    end
  end

  // Round-robin pointer: after any grant it points at the requester that lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= 1'b0;
    end else if (grant0 || grant1) begin
      rr <= grant0;
    end
  end

  // In-flight flags mark the cycle in which the memory is producing read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight0 <= 1'b0;
      inflight1 <= 1'b0;
    end else begin
      inflight0 <= grant0 && !req0_cmd;
      inflight1 <= grant1 && !req1_cmd;
    end
  end

  // Response registers for requester 0. Capture and drain cannot coincide,
  // because a read is never issued while the slot is full and not being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_dout  <= '0;
    end else if (inflight0) begin
      rsp0_valid <= 1'b1;
      rsp0_dout  <= mem_dout;
    end else if (rsp0_valid && rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  // Response registers for requester 1. They work the same way as requester 0's.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid <= 1'b0;
      rsp1_dout  <= '0;
    end else if (inflight1) begin
      rsp1_valid <= 1'b1;
      rsp1_dout  <= mem_dout;
    end else if (rsp1_valid && rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. It has a behavioural memory and a reference model built
// from cycle stamps, a shadow memory and a last-loser pointer. The model predicts
// grants, memory drive and responses on every cycle.
module tb_mem_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid, req0_ready, req0_cmd, rsp0_valid, rsp0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_din, rsp0_dout;
  logic          req1_valid, req1_ready, req1_cmd, rsp1_valid, rsp1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_din, rsp1_dout;
  logic          mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] mem_array [16] = '{default: '0};

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req0_addr(req0_addr), .req0_din(req0_din),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_dout(rsp0_dout),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .req1_addr(req1_addr), .req1_din(req1_din),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_dout(rsp1_dout),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory with a one-cycle registered read.
  always @(posedge clk) begin
    if (mem_cmd) mem_array[mem_addr] <= mem_din;
    else         mem_dout <= mem_array[mem_addr];
  end

  int total = 0;
  int bad   = 0;

  // Stimulus requested for each requester.
  bit            d_valid [2];
  bit            d_cmd   [2];
  logic [AW-1:0] d_addr  [2];
  logic [DW-1:0] d_din   [2];
  bit            d_rready[2];

  // Reference model state.
  logic [DW-1:0] sm      [16];
  bit            m_pend  [2];
  int            m_due   [2];
  logic [DW-1:0] m_pdata [2];
  bit            m_rv    [2];
  logic [DW-1:0] m_rd    [2];
  int            m_ptr;
  int            cyc;
  bit            g_last  [2];
  logic          obs_ready[2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    req0_valid = d_valid[0]; req0_cmd = d_cmd[0]; req0_addr = d_addr[0];
    req0_din = d_din[0]; rsp0_ready = d_rready[0];
    req1_valid = d_valid[1]; req1_cmd = d_cmd[1]; req1_addr = d_addr[1];
    req1_din = d_din[1]; rsp1_ready = d_rready[1];
  endtask

  task automatic model_clear();
    for (int n = 0; n < 2; n++) begin
      m_pend[n] = 0; m_rv[n] = 0; m_rd[n] = '0; g_last[n] = 0;
    end
    m_ptr = 0;
  endtask

  // One clock cycle: drive, predict, compare, then advance the model past the edge.
  task automatic step();
    bit el[2];
    int w;
    @(negedge clk);
    apply();
    #1;
    for (int n = 0; n < 2; n++)
      if (m_pend[n] && m_due[n] <= cyc) begin
        m_rv[n] = 1; m_rd[n] = m_pdata[n]; m_pend[n] = 0;
      end
    for (int n = 0; n < 2; n++)
      el[n] = d_valid[n] && (d_cmd[n] || (!m_pend[n] && (!m_rv[n] || d_rready[n])));
    if (el[0] && el[1]) w = m_ptr;
    else if (el[0])     w = 0;
    else if (el[1])     w = 1;
    else                w = -1;
    obs_ready[0] = req0_ready;
    obs_ready[1] = req1_ready;
    chk("req0_ready", 32'(req0_ready), 32'(w == 0));
    chk("req1_ready", 32'(req1_ready), 32'(w == 1));
    chk("mem_cmd",  32'(mem_cmd),  (w >= 0) ? 32'(d_cmd[w]) : 32'd0);
    chk("mem_addr", 32'(mem_addr), (w >= 0) ? 32'(d_addr[w]) : 32'd0);
    if (w >= 0 && d_cmd[w]) chk("mem_din", mem_din, d_din[w]);
    if (w < 0) chk("mem_din_idle", mem_din, 32'd0);
    chk("rsp0_valid", 32'(rsp0_valid), 32'(m_rv[0]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(m_rv[1]));
    chk("rsp0_dout", rsp0_dout, m_rd[0]);
    chk("rsp1_dout", rsp1_dout, m_rd[1]);
    chk("ready_both", 32'(req0_ready && req1_ready), 32'd0);
    g_last[0] = (w == 0);
    g_last[1] = (w == 1);
    if (w >= 0) begin
      if (d_cmd[w]) sm[d_addr[w]] = d_din[w];
      else begin
        m_pend[w] = 1; m_pdata[w] = sm[d_addr[w]]; m_due[w] = cyc + 2;
      end
      m_ptr = 1 - w;
    end
    for (int n = 0; n < 2; n++)
      if (m_rv[n] && d_rready[n]) m_rv[n] = 0;
    cyc++;
  endtask

  // Assert reset asynchronously between clock edges and check the outputs at once.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_mem_cmd",    32'(mem_cmd),    32'd0);
    chk("rst_mem_addr",   32'(mem_addr),   32'd0);
    chk("rst_mem_din",    mem_din,         32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_dout",  rsp0_dout,       32'd0);
    chk("rst_rsp1_dout",  rsp1_dout,       32'd0);
    for (int n = 0; n < 2; n++) d_valid[n] = 0;
    apply();
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(int n, bit c, logic [AW-1:0] a, logic [DW-1:0] din, output int waited);
    d_valid[n] = 1; d_cmd[n] = c; d_addr[n] = a; d_din[n] = din;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!g_last[n] && waited < 20);
    if (waited >= 20) chk("grant_timeout", 32'(obs_ready[n]), 32'd1);
    d_valid[n] = 0;
  endtask

  int wt;
  logic [DW-1:0] held;

  initial begin
    for (int i = 0; i < 16; i++) sm[i] = '0;
    for (int n = 0; n < 2; n++) begin
      d_valid[n] = 0; d_cmd[n] = 0; d_addr[n] = '0; d_din[n] = '0; d_rready[n] = 1;
    end
    cyc = 0;
    model_clear();
    apply();
    do_reset();

    // Write then read back on requester 0.
    issue(0, 1'b1, 4'd3, 32'hDEADBEEF, wt);
    issue(0, 1'b0, 4'd3, '0, wt);
    step();
    chk("t2_early", 32'(rsp0_valid), 32'd0);
    step();
    chk("t2_valid", 32'(rsp0_valid), 32'd1);
    chk("t2_dout", rsp0_dout, 32'hDEADBEEF);
    chk("t2_rsp1", 32'(rsp1_valid), 32'd0);

    // Both requesters write back to back: grants must alternate, starting with 0.
    do_reset();
    for (int n = 0; n < 2; n++) begin
      d_valid[n] = 1; d_cmd[n] = 1; d_addr[n] = 4'(8 + n);
    end
    for (int k = 0; k < 10; k++) begin
      d_din[0] = (g_last[0] || k == 0) ? 32'h1000 + k : d_din[0];
      d_din[1] = (g_last[1] || k == 0) ? 32'h2000 + k : d_din[1];
      step();
      chk("t3_alt0", 32'(req0_ready), 32'(k % 2 == 0));
      chk("t3_alt1", 32'(req1_ready), 32'(k % 2 == 1));
    end
    d_valid[0] = 0; d_valid[1] = 0;
    issue(0, 1'b0, 4'd8, '0, wt);
    issue(1, 1'b0, 4'd9, '0, wt);
    step(); step();

    // Backpressure on requester 0.
    issue(0, 1'b1, 4'd7, 32'hA5A50007, wt);
    d_rready[0] = 0;
    issue(0, 1'b0, 4'd7, '0, wt);
    step(); step();
    held = rsp0_dout;
    chk("t4_held_val", held, 32'hA5A50007);
    issue(0, 1'b1, 4'd9, 32'h99, wt);
    chk("t4_write_wait", 32'(wt), 32'd1);
    d_valid[0] = 1; d_cmd[0] = 0; d_addr[0] = 4'd3;
    d_valid[1] = 1; d_cmd[1] = 0; d_addr[1] = 4'd8;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_stall", 32'(req0_ready), 32'd0);
      chk("t4_stable", rsp0_dout, held);
      if (g_last[1]) d_addr[1] = 4'(k);
    end
    d_valid[1] = 0;
    d_rready[0] = 1;
    step();
    chk("t4_release", 32'(req0_ready), 32'd1);
    d_valid[0] = 0;
    for (int k = 0; k < 4; k++) step();

    // Cross-requester write then read of the same address.
    issue(1, 1'b1, 4'd5, 32'h12345678, wt);
    issue(0, 1'b0, 4'd5, '0, wt);
    step(); step();
    chk("t5_dout", rsp0_dout, 32'h12345678);
    chk("t5_valid", 32'(rsp0_valid), 32'd1);
    step();

    // Reset in the cycle after a read issue discards that read.
    issue(0, 1'b0, 4'd5, '0, wt);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_rsp", 32'(rsp0_valid), 32'd0);
    end
    issue(0, 1'b0, 4'd3, '0, wt);
    step(); step();
    chk("t6_after", rsp0_dout, 32'hDEADBEEF);

    // Random traffic, with each request held until it is accepted.
    for (int k = 0; k < 400; k++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(d_valid[n] && !g_last[n])) begin
          d_valid[n] = ($urandom_range(0, 9) < 7);
          d_cmd[n]   = 1'($urandom_range(0, 1));
          d_addr[n]  = 4'($urandom_range(0, 15));
          d_din[n]   = $urandom;
        end
        d_rready[n] = ($urandom_range(0, 9) < 7);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
